// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver with a show-ahead byte FIFO and a ready/valid drain port.
// Optional build macro UART_RX_MAJORITY_EN: every bit decision uses a 2-of-3 majority of the
// synchronized line over the decision cycle and the two cycles before it.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          CLK,
   input  logic                          SW1,
   input  logic                          RX,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          frame_err,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] TC    = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID   = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [AW:0]   FULL  = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

   state_t            state_r, state_nx_s;
   logic              sync1_r, rx_s, rx_s_d;
   logic              sample_s, fall_s, tc_s, mid_s;
   logic              cnt_clr_s, idx_clr_s, data_shift_s, stop_eval_s;
   logic [CW-1:0]     bit_cnt_r;
   logic [2:0]        bit_idx_r;
   logic [7:0]        shreg_r;
   logic [7:0]        mem_r [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_r, rd_ptr_r, rd_nx_s;
   logic [AW:0]       count_r, count_nx_s;
   logic [7:0]        rx_data_r, head_nx_s;
   logic              valid_r, frame_err_r, overrun_r;
   logic              pop_s, push_s, drop_s, ferr_s, full_s;

   // Two-flop synchronizer plus one delay stage for falling-edge detection
   always_ff @(posedge CLK or posedge SW1) begin
      if (SW1) begin
         sync1_r <= 1'b1;
         rx_s    <= 1'b1;
         rx_s_d  <= 1'b1;
      end else begin
         sync1_r <= RX;
         rx_s    <= sync1_r;
         rx_s_d  <= rx_s;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_r;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Two-deep history of the synchronized line feeding the majority vote
   always_ff @(posedge CLK or posedge SW1) begin
      if (SW1) hist_r <= 2'b11;
      else     hist_r <= {hist_r[0], rx_s};
   end

   assign sample_s = maj3(rx_s, hist_r[0], hist_r[1]);
`else
   assign sample_s = rx_s;
`endif

   assign fall_s = rx_s_d & ~rx_s;
   assign tc_s   = (bit_cnt_r == TC);
   assign mid_s  = (bit_cnt_r == MID);

   // FSM state register
   always_ff @(posedge CLK or posedge SW1) begin
      if (SW1) state_r <= IDLE;
      else     state_r <= state_nx_s;
   end

   // FSM next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE:    state_nx_s = fall_s ? START : IDLE;
         START:   state_nx_s = mid_s ? (sample_s ? IDLE : DATA) : START;
         DATA:    state_nx_s = (tc_s && bit_idx_r == 3'd7) ? STOP : DATA;
         STOP:    state_nx_s = tc_s ? IDLE : STOP;
         default: state_nx_s = IDLE;
      endcase
   end

   // FSM control outputs for the bit timer, shifter and stop-bit evaluation
   always_comb begin
      cnt_clr_s    = 1'b0;
      idx_clr_s    = 1'b0;
      data_shift_s = 1'b0;
      stop_eval_s  = 1'b0;
      case (state_r)
         IDLE:    cnt_clr_s    = fall_s;
         START: begin
                  cnt_clr_s    = mid_s;
                  idx_clr_s    = mid_s;
         end
         DATA:    data_shift_s = tc_s;
         STOP:    stop_eval_s  = tc_s;
         default: cnt_clr_s    = 1'b1;
      endcase
   end

   // Bit timer, bit index and LSB-first shift register
   always_ff @(posedge CLK or posedge SW1) begin
      if (SW1) begin
         bit_cnt_r <= '0;
         bit_idx_r <= 3'd0;
         shreg_r   <= 8'h00;
      end else begin
         bit_cnt_r <= (cnt_clr_s || tc_s) ? '0 : bit_cnt_r + CW'(1);
         if (idx_clr_s) begin
            bit_idx_r <= 3'd0;
         end else if (data_shift_s) begin
            bit_idx_r <= bit_idx_r + 3'd1;
            shreg_r   <= {sample_s, shreg_r[7:1]};
         end
      end
   end

   assign pop_s  = valid_r & rx_ready;
   assign full_s = (count_r == FULL);
   assign push_s = stop_eval_s & sample_s & (~full_s | pop_s);
   assign drop_s = stop_eval_s & sample_s & full_s & ~pop_s;
   assign ferr_s = stop_eval_s & ~sample_s;
   assign rd_nx_s = rd_ptr_r + AW'(pop_s);

   // Next occupancy and next head byte; a push into the slot becoming the head bypasses memory
   always_comb begin
      count_nx_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nx_s = count_r + (AW+1)'(1);
         2'b01:   count_nx_s = count_r - (AW+1)'(1);
         default: count_nx_s = count_r;
      endcase
      if (push_s && (wr_ptr_r == rd_nx_s)) head_nx_s = shreg_r;
      else                                 head_nx_s = mem_r[rd_nx_s];
   end

   // FIFO storage array
   always_ff @(posedge CLK) begin
      if (push_s) mem_r[wr_ptr_r] <= shreg_r;
   end

   // FIFO pointers, occupancy, registered head byte and status pulses
   always_ff @(posedge CLK or posedge SW1) begin
      if (SW1) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         rx_data_r   <= 8'h00;
         valid_r     <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         wr_ptr_r    <= wr_ptr_r + AW'(push_s);
         rd_ptr_r    <= rd_nx_s;
         count_r     <= count_nx_s;
         rx_data_r   <= head_nx_s;
         valid_r     <= (count_nx_s != '0);
         frame_err_r <= ferr_s;
         overrun_r   <= drop_s;
      end
   end

   assign rx_data    = rx_data_r;
   assign rx_valid   = valid_r;
   assign fifo_count = count_r;
   assign frame_err  = frame_err_r;
   assign overrun    = overrun_r;

endmodule
